// File: rtl/mem_access_unit.sv
// mem_access_unit
// Sequential load/store router between the core LSU and DEVICE_COUNT
// memory-mapped device windows. One request is accepted per handshake in
// IDLE, decoded to the highest-index window that contains the address,
// driven to that device as a byte-enabled transaction held until dev_ack
// (or until the timeout expires), and answered with a single-cycle response.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   req_*                    LSU request (valid/ready handshake, we, unit,
//                            signed, byte address, right-aligned store data)
//   rsp_*                    one-cycle response: extended load data and the
//                            access-fault / misaligned flags
//   dev_req/we/be/addr/wd    per-device transaction outputs, flat vectors
//                            (device i occupies slice i of each vector)
//   dev_ack/rd               per-device completion and read word
//   dev_ro                   per-device read-only window flag
//   dev_addr_start/end       per-device inclusive window bounds

module mem_access_unit #(
    parameter int DEVICE_COUNT   = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [1:0]                req_unit,
    input  logic                      req_signed,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wd,
    output logic                      rsp_valid,
    output logic [31:0]               rsp_rd,
    output logic                      rsp_access_fault,
    output logic                      rsp_addr_misaligned,
    output logic [DEVICE_COUNT-1:0]   dev_req,
    output logic [DEVICE_COUNT-1:0]   dev_we,
    output logic [4*DEVICE_COUNT-1:0] dev_be,
    output logic [30*DEVICE_COUNT-1:0] dev_addr,
    output logic [32*DEVICE_COUNT-1:0] dev_wd,
    input  logic [DEVICE_COUNT-1:0]   dev_ack,
    input  logic [32*DEVICE_COUNT-1:0] dev_rd,
    input  logic [DEVICE_COUNT-1:0]   dev_ro,
    input  logic [32*DEVICE_COUNT-1:0] dev_addr_start,
    input  logic [32*DEVICE_COUNT-1:0] dev_addr_end
);

    localparam int IW = (DEVICE_COUNT > 1) ? $clog2(DEVICE_COUNT) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t        state;
    logic [CW-1:0] timeout_cnt;
    logic [IW-1:0] sel_idx;
    logic [29:0]   r_addr;
    logic [3:0]    r_be;
    logic [31:0]   r_wd;
    logic          r_we;
    logic [1:0]    r_unit;
    logic          r_signed;

    logic          hit;
    logic [IW-1:0] hit_idx;
    logic [31:0]   win_start;
    logic [31:0]   offset;
    logic [3:0]    dec_be;
    logic [31:0]   dec_wd;
    logic          dec_misaligned;
    logic          dec_illegal;

    logic [31:0]   sel_rd;
    logic          sel_ack;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   rd_ext;

    // Window decode. Later (higher-index) hits overwrite earlier ones, so the
    // highest overlapping window wins. With no hit win_start stays 0 and the
    // offset degenerates to the raw address, which only feeds the alignment
    // check in that case.
    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        win_start = '0;
        for (int i = 0; i < DEVICE_COUNT; i++) begin
            if (req_addr >= dev_addr_start[32*i +: 32] &&
                req_addr <= dev_addr_end[32*i +: 32]) begin
                hit       = 1'b1;
                hit_idx   = IW'(i);
                win_start = dev_addr_start[32*i +: 32];
            end
        end
        offset = req_addr - win_start;
    end

    // Big-endian lane selection: offset 0 is the most significant byte.
    // Store data is replicated across lanes; the byte enables pick the lane.
    always_comb begin
        dec_be         = '0;
        dec_wd         = '0;
        dec_misaligned = 1'b0;
        dec_illegal    = 1'b0;
        case (req_unit)
            2'b00: begin
                dec_be = 4'b1000 >> offset[1:0];
                dec_wd = {4{req_wd[7:0]}};
            end
            2'b01: begin
                dec_be         = offset[1] ? 4'b0011 : 4'b1100;
                dec_wd         = {2{req_wd[15:0]}};
                dec_misaligned = offset[0];
            end
            2'b10: begin
                dec_be         = 4'b1111;
                dec_wd         = req_wd;
                dec_misaligned = |offset[1:0];
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Read path: pick the chosen device's word and ack, then pull the lane
    // named by the registered byte enables down to bit 0 and extend it.
    always_comb begin
        sel_rd  = '0;
        sel_ack = 1'b0;
        for (int i = 0; i < DEVICE_COUNT; i++) begin
            if (sel_idx == IW'(i)) begin
                sel_rd  = dev_rd[32*i +: 32];
                sel_ack = dev_ack[i];
            end
        end
        case (r_be)
            4'b1000: rd_byte = sel_rd[31:24];
            4'b0100: rd_byte = sel_rd[23:16];
            4'b0010: rd_byte = sel_rd[15:8];
            default: rd_byte = sel_rd[7:0];
        endcase
        rd_half = r_be[3] ? sel_rd[31:16] : sel_rd[15:0];
        case (r_unit)
            2'b00:   rd_ext = {{24{r_signed & rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = {{16{r_signed & rd_half[15]}}, rd_half};
            default: rd_ext = sel_rd;
        endcase
    end

    // Only the chosen device sees a transaction, and only while waiting for
    // its ack; every other slice is held at zero.
    always_comb begin
        dev_req  = '0;
        dev_we   = '0;
        dev_be   = '0;
        dev_addr = '0;
        dev_wd   = '0;
        for (int i = 0; i < DEVICE_COUNT; i++) begin
            if (state == ST_WAIT && sel_idx == IW'(i)) begin
                dev_req[i]           = 1'b1;
                dev_we[i]            = r_we;
                dev_be[4*i +: 4]     = r_be;
                dev_addr[30*i +: 30] = r_addr;
                dev_wd[32*i +: 32]   = r_wd;
            end
        end
    end

    assign req_ready = (state == ST_IDLE);

    // Control FSM. Faulted decodes skip WAIT and answer on the next cycle;
    // misalignment takes precedence over every access-fault cause.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            timeout_cnt         <= '0;
            sel_idx             <= '0;
            r_addr              <= '0;
            r_be                <= '0;
            r_wd                <= '0;
            r_we                <= 1'b0;
            r_unit              <= '0;
            r_signed            <= 1'b0;
            rsp_valid           <= 1'b0;
            rsp_rd              <= '0;
            rsp_access_fault    <= 1'b0;
            rsp_addr_misaligned <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (dec_misaligned) begin
                            rsp_valid           <= 1'b1;
                            rsp_rd              <= '0;
                            rsp_access_fault    <= 1'b0;
                            rsp_addr_misaligned <= 1'b1;
                            state               <= ST_RESP;
                        end else if (dec_illegal || !hit || (req_we && dev_ro[hit_idx])) begin
                            rsp_valid           <= 1'b1;
                            rsp_rd              <= '0;
                            rsp_access_fault    <= 1'b1;
                            rsp_addr_misaligned <= 1'b0;
                            state               <= ST_RESP;
                        end else begin
                            sel_idx     <= hit_idx;
                            r_addr      <= offset[31:2];
                            r_be        <= dec_be;
                            r_wd        <= dec_wd;
                            r_we        <= req_we;
                            r_unit      <= req_unit;
                            r_signed    <= req_signed;
                            timeout_cnt <= '0;
                            state       <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (sel_ack) begin
                        rsp_valid           <= 1'b1;
                        rsp_rd              <= r_we ? 32'd0 : rd_ext;
                        rsp_access_fault    <= 1'b0;
                        rsp_addr_misaligned <= 1'b0;
                        timeout_cnt         <= '0;
                        state               <= ST_RESP;
                    end else if (timeout_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        rsp_valid           <= 1'b1;
                        rsp_rd              <= '0;
                        rsp_access_fault    <= 1'b1;
                        rsp_addr_misaligned <= 1'b0;
                        timeout_cnt         <= '0;
                        state               <= ST_RESP;
                    end else begin
                        timeout_cnt <= timeout_cnt + CW'(1);
                    end
                end
                default: begin
                    timeout_cnt         <= '0;
                    rsp_rd              <= '0;
                    rsp_access_fault    <= 1'b0;
                    rsp_addr_misaligned <= 1'b0;
                    state               <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Self-checking bench for mem_access_unit with three windows (window 2
// overlaps window 0 and is read-only) and a short timeout. A transaction
// model works out, from plain address arithmetic, which device must be
// addressed, with which lanes and data, and what the response must carry.
// The stimulus sets per-cycle expectations; one compare process checks them
// at every falling edge.

module tb_mem_access_unit;

    localparam int DC = 3;
    localparam int TO = 4;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_unit;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wd;
    logic              rsp_valid;
    logic [31:0]       rsp_rd;
    logic              rsp_access_fault;
    logic              rsp_addr_misaligned;
    logic [DC-1:0]     dev_req;
    logic [DC-1:0]     dev_we;
    logic [4*DC-1:0]   dev_be;
    logic [30*DC-1:0]  dev_addr;
    logic [32*DC-1:0]  dev_wd;
    logic [DC-1:0]     dev_ack;
    logic [32*DC-1:0]  dev_rd;
    logic [DC-1:0]     dev_ro;
    logic [32*DC-1:0]  dev_addr_start;
    logic [32*DC-1:0]  dev_addr_end;

    logic [31:0] win_start [DC];
    logic [31:0] win_end   [DC];
    logic        win_ro    [DC];

    int n_checks;
    int n_fail;

    // Per-cycle expectations, written just after each rising edge.
    logic              chk_on;
    logic              exp_ready;
    logic [DC-1:0]     exp_dev_req;
    logic              exp_dev_cmp;
    logic [DC-1:0]     exp_dev_we;
    logic [4*DC-1:0]   exp_dev_be;
    logic [30*DC-1:0]  exp_dev_addr;
    logic [32*DC-1:0]  exp_dev_wd;
    logic              exp_rsp_valid;
    logic              exp_rsp_cmp;
    logic [31:0]       exp_rsp_rd;
    logic              exp_af;
    logic              exp_mis;

    typedef struct {
        bit          access;
        bit          mis;
        bit          af;
        int          idx;
        logic [31:0] off;
        logic [3:0]  be;
        logic [29:0] laddr;
        logic [31:0] wd;
    } model_t;

    mem_access_unit #(
        .DEVICE_COUNT   (DC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_we              (req_we),
        .req_unit            (req_unit),
        .req_signed          (req_signed),
        .req_addr            (req_addr),
        .req_wd              (req_wd),
        .rsp_valid           (rsp_valid),
        .rsp_rd              (rsp_rd),
        .rsp_access_fault    (rsp_access_fault),
        .rsp_addr_misaligned (rsp_addr_misaligned),
        .dev_req             (dev_req),
        .dev_we              (dev_we),
        .dev_be              (dev_be),
        .dev_addr            (dev_addr),
        .dev_wd              (dev_wd),
        .dev_ack             (dev_ack),
        .dev_rd              (dev_rd),
        .dev_ro              (dev_ro),
        .dev_addr_start      (dev_addr_start),
        .dev_addr_end        (dev_addr_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < DC; i++) begin
            dev_addr_start[32*i +: 32] = win_start[i];
            dev_addr_end[32*i +: 32]   = win_end[i];
            dev_ro[i]                  = win_ro[i];
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Decode the request the way the address map describes it: scan windows
    // from the highest index down and take the first containing one.
    function automatic model_t model_decode(input bit we, input logic [1:0] unit,
                                            input logic [31:0] addr, input logic [31:0] wd);
        model_t m;
        int     hit;
        m.access = 0; m.mis = 0; m.af = 0; m.idx = 0;
        m.off = '0; m.be = '0; m.laddr = '0; m.wd = '0;
        hit = -1;
        for (int i = DC - 1; i >= 0; i--)
            if (hit < 0 && addr >= win_start[i] && addr <= win_end[i]) hit = i;
        m.off = (hit >= 0) ? addr - win_start[hit] : addr;
        if ((unit == 2'd1 && m.off[0]) || (unit == 2'd2 && m.off[1:0] != 2'd0)) begin
            m.mis = 1;
            return m;
        end
        if (unit == 2'd3 || hit < 0 || (we && win_ro[hit])) begin
            m.af = 1;
            return m;
        end
        m.access = 1;
        m.idx    = hit;
        m.laddr  = m.off[31:2];
        case (unit)
            2'd0: begin
                m.be = 4'b0001 << (3 - int'(m.off[1:0]));
                m.wd = {24'd0, wd[7:0]} * 32'h0101_0101;
            end
            2'd1: begin
                m.be = 4'b0011 << (2 * (1 - int'(m.off[1])));
                m.wd = {16'd0, wd[15:0]} * 32'h0001_0001;
            end
            default: begin
                m.be = 4'b1111;
                m.wd = wd;
            end
        endcase
        return m;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] unit, input bit sgn,
                                               input logic [31:0] off, input logic [31:0] rd);
        logic [31:0] v;
        case (unit)
            2'd0: begin
                v = (rd >> (8 * (3 - int'(off[1:0])))) & 32'hFF;
                if (sgn && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'd1: begin
                v = (rd >> (16 * (1 - int'(off[1])))) & 32'hFFFF;
                if (sgn && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    task automatic set_idle();
        exp_ready     = 1'b1;
        exp_dev_req   = '0;
        exp_dev_cmp   = 1'b0;
        exp_rsp_valid = 1'b0;
        exp_rsp_cmp   = 1'b0;
    endtask

    task automatic set_all_zero();
        set_idle();
        exp_dev_cmp  = 1'b1;
        exp_dev_we   = '0;
        exp_dev_be   = '0;
        exp_dev_addr = '0;
        exp_dev_wd   = '0;
        exp_rsp_cmp  = 1'b1;
        exp_rsp_rd   = '0;
        exp_af       = 1'b0;
        exp_mis      = 1'b0;
    endtask

    task automatic set_wait(input model_t m, input bit we);
        set_all_zero();
        exp_ready                   = 1'b0;
        exp_rsp_cmp                 = 1'b0;
        exp_dev_req[m.idx]          = 1'b1;
        exp_dev_we[m.idx]           = we;
        exp_dev_be[4*m.idx +: 4]    = m.be;
        exp_dev_addr[30*m.idx +: 30] = m.laddr;
        exp_dev_wd[32*m.idx +: 32]  = m.wd;
    endtask

    task automatic randomize_devs();
        for (int i = 0; i < DC; i++) dev_rd[32*i +: 32] = $urandom;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: present the request for one idle cycle, play
    // the device side (ack in WAIT cycle ack_k; ack_k > TO withholds it),
    // then expect the one-cycle response.
    task automatic applyStimulus(input bit we, input logic [1:0] unit, input bit sgn,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input int ack_k, input logic [31:0] rd_word, input bit stray);
        model_t m;
        bit     acked;
        int     other;
        m = model_decode(we, unit, addr, wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_unit   = unit;
        req_signed = sgn;
        req_addr   = addr;
        req_wd     = wd;
        set_idle();
        next_cycle();
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_unit   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wd     = $urandom;
        acked = 0;
        if (m.access) begin
            other = (m.idx + 1) % DC;
            for (int k = 1; k <= TO; k++) begin
                set_wait(m, we);
                randomize_devs();
                dev_ack = '0;
                if (k == ack_k) begin
                    dev_ack[m.idx]          = 1'b1;
                    dev_rd[32*m.idx +: 32]  = rd_word;
                    acked = 1;
                end else if (stray) begin
                    dev_ack[other] = 1'b1;
                end
                next_cycle();
                dev_ack = '0;
                if (acked) break;
            end
        end
        set_idle();
        exp_ready     = 1'b0;
        exp_rsp_valid = 1'b1;
        exp_rsp_cmp   = 1'b1;
        exp_rsp_rd    = (acked && !we) ? model_read(unit, sgn, m.off, rd_word) : 32'd0;
        exp_af        = m.af || (m.access && !acked);
        exp_mis       = m.mis;
        next_cycle();
        set_idle();
    endtask

    // Pull reset low for one cycle while a load is outstanding.
    task automatic reset_in_wait();
        model_t m;
        m = model_decode(1'b0, 2'd2, 32'h1000_0010, 32'd0);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_unit   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 32'h1000_0010;
        req_wd     = 32'd0;
        set_idle();
        next_cycle();
        req_valid = 1'b0;
        set_wait(m, 1'b0);
        next_cycle();
        set_wait(m, 1'b0);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        set_all_zero();
        next_cycle();
        set_idle();
        next_cycle();
    endtask

    // The single compare process: every falling edge once checking is on.
    always @(negedge clk) begin
        if (chk_on) begin
            checkOutput("req_ready", 128'(req_ready), 128'(exp_ready));
            checkOutput("dev_req", 128'(dev_req), 128'(exp_dev_req));
            checkOutput("rsp_valid", 128'(rsp_valid), 128'(exp_rsp_valid));
            if (exp_dev_cmp) begin
                checkOutput("dev_we", 128'(dev_we), 128'(exp_dev_we));
                checkOutput("dev_be", 128'(dev_be), 128'(exp_dev_be));
                checkOutput("dev_addr", 128'(dev_addr), 128'(exp_dev_addr));
                checkOutput("dev_wd", 128'(dev_wd), 128'(exp_dev_wd));
            end
            if (exp_rsp_cmp) begin
                checkOutput("rsp_rd", 128'(rsp_rd), 128'(exp_rsp_rd));
                checkOutput("rsp_access_fault", 128'(rsp_access_fault), 128'(exp_af));
                checkOutput("rsp_addr_misaligned", 128'(rsp_addr_misaligned), 128'(exp_mis));
            end
        end
    end

    initial begin
        model_t      pm;
        int          r;
        logic [31:0] a;
        logic [1:0]  u;

        n_checks = 0;
        n_fail   = 0;
        chk_on   = 1'b0;
        set_all_zero();

        win_start[0] = 32'h0000_0000; win_end[0] = 32'h0000_0FFF; win_ro[0] = 1'b0;
        win_start[1] = 32'h1000_0000; win_end[1] = 32'h1000_00FF; win_ro[1] = 1'b0;
        win_start[2] = 32'h0000_0800; win_end[2] = 32'h0000_08FF; win_ro[2] = 1'b1;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_unit   = 2'd0;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wd     = '0;
        dev_ack    = '0;
        dev_rd     = '0;

        // Hand-computed values that pin the model itself.
        pm = model_decode(1'b0, 2'd0, 32'h0000_0003, 32'd0);
        checkOutput("model_byte_be", 128'(pm.be), 128'(4'b0001));
        checkOutput("model_byte_addr", 128'(pm.laddr), 128'(0));
        checkOutput("model_byte_rd", 128'(model_read(2'd0, 1'b1, pm.off, 32'h1122_33F4)), 128'(32'hFFFF_FFF4));
        pm = model_decode(1'b1, 2'd1, 32'h1000_0006, 32'h0000_ABCD);
        checkOutput("model_half_idx", 128'(pm.idx), 128'(1));
        checkOutput("model_half_addr", 128'(pm.laddr), 128'(1));
        checkOutput("model_half_be", 128'(pm.be), 128'(4'b0011));
        checkOutput("model_half_wd", 128'(pm.wd[15:0]), 128'(16'hABCD));
        checkOutput("model_half_rd", 128'(model_read(2'd1, 1'b1, 32'h2, 32'h1234_8001)), 128'(32'hFFFF_8001));
        pm = model_decode(1'b0, 2'd2, 32'h0000_0002, 32'd0);
        checkOutput("model_misaligned", 128'(pm.mis), 128'(1));
        pm = model_decode(1'b0, 2'd2, 32'h2000_0000, 32'd0);
        checkOutput("model_unmapped", 128'(pm.af), 128'(1));
        pm = model_decode(1'b0, 2'd2, 32'h0000_0804, 32'd0);
        checkOutput("model_overlap_idx", 128'(pm.idx), 128'(2));

        next_cycle();
        next_cycle();
        chk_on = 1'b1;
        next_cycle();
        rst_n = 1'b1;
        set_idle();
        next_cycle();

        $display("[TB] directed transactions");
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h0000_0003, 32'd0, 2, 32'h1122_33F4, 1'b0);
        applyStimulus(1'b1, 2'd1, 1'b0, 32'h1000_0006, 32'h0000_ABCD, 1, 32'h5555_5555, 1'b1);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'd0, 1, 32'd0, 1'b0);
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h0000_0800, 32'hDEAD_BEEF, 1, 32'd0, 1'b0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h2000_0000, 32'd0, 1, 32'd0, 1'b0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, TO + 1, 32'd0, 1'b1);
        reset_in_wait();
        applyStimulus(1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'd0, 1, 32'd0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h1000_00FF, 32'd0, 3, 32'hA1B2_C3D4, 1'b1);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h1000_0100, 32'd0, 1, 32'd0, 1'b0);
        applyStimulus(1'b0, 2'd1, 1'b1, 32'h0000_08FE, 32'd0, TO, 32'h1234_8001, 1'b0);
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h0000_0900, 32'h0000_0077, 1, 32'd0, 1'b0);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: a = 32'($urandom_range(0, 32'h0FFF));
                4, 5:       a = 32'h1000_0000 + 32'($urandom_range(0, 255));
                6, 7:       a = 32'h0000_0800 + 32'($urandom_range(0, 255));
                8:          a = 32'h2000_0000 + 32'($urandom_range(0, 4095));
                default:    a = $urandom;
            endcase
            r = $urandom_range(0, 9);
            u = (r == 9) ? 2'd3 : 2'(r % 3);
            applyStimulus(1'($urandom), u, 1'($urandom), a, $urandom,
                          $urandom_range(1, TO + 1), $urandom, 1'($urandom));
            if ($urandom_range(0, 3) == 0) next_cycle();
        end

        next_cycle();
        next_cycle();
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
